// File: rtl/ad1868_capture.sv
// AD1868-style serial DAC bus decoder: oversamples the source bus in the MCLK domain,
// captures one word per channel and hands 16-bit samples to the I2S encoder on its latch.
module ad1868_capture #(
    parameter int DATA_BITS   = 18,
    parameter int SYNC_STAGES = 2
) (
    input  logic        w_clk,
    input  logic        i_rst_x,
    input  logic        i_ad_clk,
    input  logic        i_ad_dl,
    input  logic        i_ad_dr,
    input  logic        i_ad_ll,
    input  logic        i_ad_lr,
    input  logic        i_latch,
    output logic [15:0] o_data_l,
    output logic [15:0] o_data_r,
    output logic        o_valid,
    output logic        o_short,
    output logic        o_overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

    localparam int B_CLK = 0;
    localparam int B_DL  = 1;
    localparam int B_DR  = 2;
    localparam int B_LL  = 3;
    localparam int B_LR  = 4;
    localparam int B_LAT = 5;

    if (DATA_BITS < 16 || DATA_BITS > 24) begin : g_bad_width
        $error("ad1868_capture: DATA_BITS must be within 16..24");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("ad1868_capture: SYNC_STAGES must be at least 1");
    end

    logic [5:0] async_in;
    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] hist_q;
    logic [5:0] cur;

    logic clk_rise;
    logic ll_fall;
    logic lr_fall;
    logic lat_rise;

    logic [DATA_BITS-1:0] sreg_l_q;
    logic [DATA_BITS-1:0] sreg_r_q;
    logic [DATA_BITS-1:0] sreg_l_nxt;
    logic [DATA_BITS-1:0] sreg_r_nxt;
    logic [CW-1:0]        cnt_l_q;
    logic [CW-1:0]        cnt_r_q;
    logic [CW-1:0]        cnt_l_shift;
    logic [CW-1:0]        cnt_r_shift;
    logic [15:0]          pend_l_q;
    logic [15:0]          pend_r_q;
    logic                 fresh_l_q;
    logic                 fresh_r_q;
    logic                 seen_l_q;
    logic                 seen_r_q;

    logic cap_l;
    logic cap_r;
    logic short_l;
    logic short_r;
    logic ovr_l;
    logic ovr_r;

    assign async_in = {i_latch, i_ad_lr, i_ad_ll, i_ad_dr, i_ad_dl, i_ad_clk};

    // Clock and data travel through the same chain so data sampled on a detected
    // clock rise is exactly the value present at the source clock edge.
    always_ff @(posedge w_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= cur;
        end
    end

    assign cur      = sync_q[SYNC_STAGES-1];
    assign clk_rise =  cur[B_CLK] & ~hist_q[B_CLK];
    assign ll_fall  = ~cur[B_LL]  &  hist_q[B_LL];
    assign lr_fall  = ~cur[B_LR]  &  hist_q[B_LR];
    assign lat_rise =  cur[B_LAT] & ~hist_q[B_LAT];

    // Shift is evaluated before capture so a bit arriving with the latch fall still counts.
    always_comb begin
        sreg_l_nxt  = sreg_l_q;
        sreg_r_nxt  = sreg_r_q;
        cnt_l_shift = cnt_l_q;
        cnt_r_shift = cnt_r_q;
        if (clk_rise) begin
            sreg_l_nxt = {sreg_l_q[DATA_BITS-2:0], cur[B_DL]};
            sreg_r_nxt = {sreg_r_q[DATA_BITS-2:0], cur[B_DR]};
            if (cnt_l_q != FULL) begin
                cnt_l_shift = cnt_l_q + CW'(1);
            end
            if (cnt_r_q != FULL) begin
                cnt_r_shift = cnt_r_q + CW'(1);
            end
        end
    end

    // A capture coinciding with a transfer is not an overrun: the old word leaves this cycle.
    always_comb begin
        cap_l   = ll_fall && (cnt_l_shift == FULL);
        cap_r   = lr_fall && (cnt_r_shift == FULL);
        short_l = ll_fall && (cnt_l_shift != FULL);
        short_r = lr_fall && (cnt_r_shift != FULL);
        ovr_l   = cap_l && fresh_l_q && !lat_rise;
        ovr_r   = cap_r && fresh_r_q && !lat_rise;
    end

    always_ff @(posedge w_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            sreg_l_q  <= '0;
            sreg_r_q  <= '0;
            cnt_l_q   <= '0;
            cnt_r_q   <= '0;
            pend_l_q  <= '0;
            pend_r_q  <= '0;
            fresh_l_q <= 1'b0;
            fresh_r_q <= 1'b0;
            seen_l_q  <= 1'b0;
            seen_r_q  <= 1'b0;
        end else begin
            sreg_l_q <= sreg_l_nxt;
            sreg_r_q <= sreg_r_nxt;
            cnt_l_q  <= ll_fall ? '0 : cnt_l_shift;
            cnt_r_q  <= lr_fall ? '0 : cnt_r_shift;

            if (cap_l) begin
                pend_l_q  <= sreg_l_nxt[DATA_BITS-1 -: 16];
                fresh_l_q <= 1'b1;
                seen_l_q  <= 1'b1;
            end else if (lat_rise) begin
                fresh_l_q <= 1'b0;
            end

            if (cap_r) begin
                pend_r_q  <= sreg_r_nxt[DATA_BITS-1 -: 16];
                fresh_r_q <= 1'b1;
                seen_r_q  <= 1'b1;
            end else if (lat_rise) begin
                fresh_r_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge w_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            o_data_l  <= '0;
            o_data_r  <= '0;
            o_valid   <= 1'b0;
            o_short   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_short   <= short_l | short_r;
            o_overrun <= ovr_l | ovr_r;
            if (lat_rise) begin
                o_data_l <= pend_l_q;
                o_data_r <= pend_r_q;
                o_valid  <= o_valid | (seen_l_q & seen_r_q);
            end
        end
    end

endmodule
